input_ctrl: RTL and testbench

Router input-side controller: accepts 57-bit NoC packets on a single valid/ready input port, buffers them in a small FIFO, decodes the 2-bit destination field of the head packet and presents it to exactly one of four output ports. It is the demultiplexing counterpart of the router's 4-to-1 output controller. Each output port of this block connects to the matching input of an output controller.

---
 rtl/input_ctrl.sv | 120 ++++++++++++
 tb/tb_input_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/input_ctrl.sv
// input_ctrl: router input-side controller.
// Buffers NoC packets from a single valid/ready input in a small circular
// FIFO and presents the head packet to exactly one of four output ports,
// selected by the 2-bit destination field of the head packet.
// Optional feature macro: INPUT_CTRL_STATS_EN adds per-port saturating
// delivered-packet counters; when undefined, stat_count is tied to zero.
module input_ctrl #(
    parameter int WIDTH    = 57,
    parameter int DEPTH    = 2,
    parameter int DEST_LSB = 55
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [3:0]                 out_valid,
    input  logic [3:0]                 out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [3:0][15:0]           stat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             push;
    logic             pop;
    logic [3:0]       pop_vec;
    logic [1:0]       dest;
    logic [WIDTH-1:0] head;

    // Handshake qualifiers; in_ready depends on stored count only, so a pop
    // in the same cycle never lets a full buffer accept a packet.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];
    assign dest      = head[DEST_LSB+1:DEST_LSB];
    assign out_data  = head;
    assign occupancy = count_q;
    assign pop_vec   = out_valid & out_ready;
    assign pop       = |pop_vec;

    // Route the head packet to the single port named by its destination field.
    always_comb begin
        out_valid = 4'b0000;
        if (count_q != '0) begin
            out_valid = 4'b0001 << dest;
        end
    end

    // Next-state for pointers and count; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards any buffered packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; cleared on reset so out_data is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef INPUT_CTRL_STATS_EN
    logic [3:0][15:0] stat_q;

    // Per-port delivered-packet counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (pop_vec[p] && (stat_q[p] != 16'hFFFF)) begin
                    stat_q[p] <= stat_q[p] + 16'd1;
                end
            end
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = '0;
`endif

endmodule

// File: tb/tb_input_ctrl.sv
// Directed testbench for input_ctrl with immediate-assertion checks.
module tb_input_ctrl;

    localparam int WIDTH    = 57;
    localparam int DEPTH    = 2;
    localparam int DEST_LSB = 55;
`ifdef INPUT_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [3:0]             out_valid;
    logic [3:0]             out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [$clog2(DEPTH):0] occupancy;
    logic [3:0][15:0]       stat_count;

    int errors = 0;
    int checks = 0;

    input_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEST_LSB(DEST_LSB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pkt(input logic [1:0] d, input logic [31:0] payload);
        logic [WIDTH-1:0] p;
        p = '0;
        p[31:0] = payload;
        p[DEST_LSB+1:DEST_LSB] = d;
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] pa, pb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'b0000;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset / idle state
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_stat",      64'(stat_count), 64'd0);

        // Single packet to port 2
        p         = pkt(2'd2, 32'h1234);
        in_valid  = 1'b1;
        in_data   = p;
        out_ready = 4'b1111;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        check("single_out_valid", 64'(out_valid), 64'h4);
        check("single_out_data",  64'(out_data),  64'(p));
        check("single_occ",       64'(occupancy), 64'd1);
        step();
        check("single_drained_valid", 64'(out_valid), 64'd0);
        check("single_drained_occ",   64'(occupancy), 64'd0);
        check("single_stat2", 64'(stat_count[2]), STATS ? 64'd1 : 64'd0);

        // Fill to full with no ready, verify head-of-line behaviour
        out_ready = 4'b0000;
        pa        = pkt(2'd0, 32'hA0A0);
        pb        = pkt(2'd3, 32'hB0B0);
        in_valid  = 1'b1;
        in_data   = pa;
        step();
        in_data = pb;
        step();
        check("full_occ",       64'(occupancy), 64'd2);
        check("full_in_ready",  64'(in_ready),  64'd0);
        check("full_out_valid", 64'(out_valid), 64'h1);
        in_data = pkt(2'd1, 32'hC0C0);
        step();
        in_valid = 1'b0;
        check("full_reject_occ",  64'(occupancy), 64'd2);
        check("full_reject_head", 64'(out_data),  64'(pa));
        out_ready = 4'b1000;
        step();
        check("wrong_port_occ",   64'(occupancy), 64'd2);
        check("wrong_port_valid", 64'(out_valid), 64'h1);
        out_ready = 4'b0001;
        check("no_bypass_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 4'b0000;
        check("pop0_occ",   64'(occupancy), 64'd1);
        check("pop0_valid", 64'(out_valid), 64'h8);
        check("pop0_data",  64'(out_data),  64'(pb));
        check("pop0_stat0", 64'(stat_count[0]), STATS ? 64'd1 : 64'd0);

        // Refill to two entries, then asynchronous reset mid-stream
        in_valid = 1'b1;
        in_data  = pkt(2'd2, 32'hD0D0);
        step();
        in_valid = 1'b0;
        check("prereset_occ", 64'(occupancy), 64'd2);
        rst = 1'b1;
        #1;
        check("async_rst_occ",      64'(occupancy),  64'd0);
        check("async_rst_valid",    64'(out_valid),  64'd0);
        check("async_rst_in_ready", 64'(in_ready),   64'd1);
        check("async_rst_stat",     64'(stat_count), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Stream 16 packets, dest cycling 0..3, one per cycle
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            p       = pkt(2'(k % 4), 32'h100 + 32'(k));
            in_data = p;
            step();
            check("stream_data",     64'(out_data),  64'(p));
            check("stream_valid",    64'(out_valid), 64'(4'b0001 << (k % 4)));
            check("stream_occ",      64'(occupancy), 64'd1);
            check("stream_in_ready", 64'(in_ready),  64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained_occ", 64'(occupancy), 64'd0);
        for (int d = 0; d < 4; d++) begin
            check("stream_stat", 64'(stat_count[d]), STATS ? 64'd4 : 64'd0);
        end

        // Simultaneous push/pop at occupancy 1
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = pkt(2'd3, 32'h200);
        step();
        check("pp_load_occ", 64'(occupancy), 64'd1);
        out_ready = 4'b1111;
        for (int j = 1; j <= 8; j++) begin
            p       = pkt(2'((j * 3) % 4), 32'h200 + 32'(j));
            in_data = p;
            step();
            check("pp_occ",  64'(occupancy), 64'd1);
            check("pp_data", 64'(out_data),  64'(p));
        end
        in_valid = 1'b0;
        step();
        check("pp_drained_occ", 64'(occupancy), 64'd0);

`ifdef INPUT_CTRL_STATS_EN
        // Counter saturation on port 1
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = pkt(2'd1, 32'h5A5A);
        for (int n = 0; n < 65540; n++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_occ",   64'(occupancy),     64'd0);
        check("sat_stat1", 64'(stat_count[1]), 64'hFFFF);
        check("sat_stat0", 64'(stat_count[0]), 64'd0);
        check("sat_stat2", 64'(stat_count[2]), 64'd0);
        check("sat_stat3", 64'(stat_count[3]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
